// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between two requesters over
//            valid/ready request and response channels. Optional macro
//            ALU_ARB_RR_EN selects round-robin grant; otherwise port 0 wins.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][OP_W-1:0]   req_opcode,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [1:0][DATA_W-1:0] rsp_data,
    output logic [OP_W-1:0]        alu_opcode,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    input  logic [DATA_W-1:0]      alu_result
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic [DATA_W-1:0] r_result;
    logic [OP_W-1:0]   r_opcode;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              w_gnt_idx;
    logic              w_accept;

`ifdef ALU_ARB_RR_EN
    logic              r_last;

    // Under contention the port that did not win last time is served.
    always_comb begin
        w_gnt_idx = req_valid[1];
        if (req_valid == 2'b11) begin
            w_gnt_idx = ~r_last;
        end
    end
`else
    always_comb begin
        w_gnt_idx = req_valid[1] & ~req_valid[0];
    end
`endif

    assign w_accept     = (r_state == c_IDLE) && (req_valid != 2'b00);
    assign req_ready[0] = w_accept & ~w_gnt_idx;
    assign req_ready[1] = w_accept &  w_gnt_idx;

    assign rsp_valid[0] = (r_state == c_RESP) & ~r_owner;
    assign rsp_valid[1] = (r_state == c_RESP) &  r_owner;
    assign rsp_data[0]  = r_result;
    assign rsp_data[1]  = r_result;

    assign alu_opcode   = r_opcode;
    assign alu_a        = r_a;
    assign alu_b        = r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
`ifdef ALU_ARB_RR_EN
            r_last   <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_opcode <= req_opcode[w_gnt_idx];
                        r_a      <= req_a[w_gnt_idx];
                        r_b      <= req_b[w_gnt_idx];
                        r_owner  <= w_gnt_idx;
`ifdef ALU_ARB_RR_EN
                        r_last   <= w_gnt_idx;
`endif
                        r_state  <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_result <= alu_result;
                    r_state  <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter with a small reference ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][4:0]   req_opcode;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_data;
    logic [4:0]        alu_opcode;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [31:0]       alu_result;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: only the opcodes the vectors use.
    always_comb begin
        case (alu_opcode)
            5'b00000: alu_result = alu_a + alu_b;
            5'b00010: alu_result = alu_a - alu_b;
            5'b00101: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default:  alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected port=%0d actual=%h required=none", i, rsp_data[i]);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("rsp_port", 32'(i), 32'(e.port));
                        check("rsp_data", rsp_data[i], e.data);
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_v);
        bit   got;
        exp_t e;
        req_opcode[p] = op;
        req_a[p]      = a;
        req_b[p]      = b;
        req_valid[p]  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                got = 1'b1;
                break;
            end
        end
        check("accept", 32'(got), 32'd1);
        e.port = p[0];
        e.data = exp_v;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grants;
        int   last_cyc;
        bit   p;
        exp_t e;
        bit   seq[4];
        bit   got;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data0", rsp_data[0], 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op on port 0: 7 + 5.
        req_opcode[0] = 5'b00000;
        req_a[0]      = 32'd7;
        req_b[0]      = 32'd5;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'd1);
        e.port = 1'b0;
        e.data = 32'd12;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("single_exec_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_data", rsp_data[0], 32'd12);
        @(posedge clk); #1;
        check("single_done", 32'(rsp_valid), 32'd0);

        // Backpressure on port 1: 3 - 10.
        rsp_ready[1] = 1'b0;
        issue(1, 5'b00010, 32'd3, 32'd10, 32'hFFFFFFF9);
        req_valid = 2'b11;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd2);
            check("bp_data", rsp_data[1], 32'hFFFFFFF9);
            check("bp_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        req_valid    = 2'b00;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(rsp_valid), 32'd0);
        req_valid[0] = 1'b1;
        #1;
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        req_valid[0] = 1'b0;
        @(posedge clk); #1;

        // Operand isolation on port 1: ASR 0x80000000 by 4.
        issue(1, 5'b00101, 32'h80000000, 32'd4, 32'hF8000000);
        req_a[1] = 32'd0;
        req_b[1] = 32'd0;
        check("iso_alu_a", alu_a, 32'h80000000);
        @(posedge clk); #1;
        check("iso_rsp_data", rsp_data[1], 32'hF8000000);
        @(posedge clk); #1;

        // Asynchronous reset in RESP.
        rsp_ready[0] = 1'b0;
        issue(0, 5'b00010, 32'd9, 32'd4, 32'd5);
        @(posedge clk); #1;
        check("rstm_pre_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstm_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstm_req_ready", 32'(req_ready), 32'd0);
        check("rstm_alu_opcode", 32'(alu_opcode), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 2'b11;
        @(posedge clk); #1;

        // Contention with both requesters held valid.
`ifdef ALU_ARB_RR_EN
        seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        req_opcode[0] = 5'b00000;
        req_a[0]      = 32'd100;
        req_b[0]      = 32'd23;
        req_opcode[1] = 5'b00010;
        req_a[1]      = 32'd50;
        req_b[1]      = 32'd8;
        req_valid     = 2'b11;
        grants   = 0;
        last_cyc = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                p = req_ready[1];
                check("cont_order", 32'(p), 32'(seq[grants]));
                if (grants > 0) check("cont_spacing", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                e.port = p;
                e.data = p ? 32'd42 : 32'd123;
                q.push_back(e);
                grants++;
            end
        end
        check("cont_grants", 32'(grants), 32'd4);
        @(posedge clk); #1;
`ifdef ALU_ARB_RR_EN
        req_valid = 2'b00;
`else
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                got = 1'b1;
                check("fixed_port1_grant", 32'(req_ready), 32'd2);
                e.port = 1'b1;
                e.data = 32'd42;
                q.push_back(e);
                break;
            end
        end
        check("fixed_port1_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
`endif

        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
